sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter -- shares one asynchronous 16-bit SRAM between a write port
// (recorder) and a read port (DSP/player). Each access is a req/ack transaction.
// A counter FSM times the strobes. When both ports are waiting, the grant
// alternates between them.
//
// Optional feature: define SRAM_TURNAROUND_EN to insert a one-cycle TURN state
// after every write. During TURN all strobes are released and DQ is undriven.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_wr_req/addr/data        write request; held until o_wr_ack
//   o_wr_ack                  one-cycle pulse when a write has completed
//   i_rd_req/addr             read request; held until o_rd_ack
//   o_rd_ack, o_rd_data       one-cycle pulse; read data is registered and held
//   o_busy                    high while an access (or TURN) is in progress
//   o_sram_addr, io_sram_dq   SRAM address and bidirectional data bus
//   o_sram_we_n/ce_n/oe_n     SRAM strobes
//   o_sram_lb_n/ub_n          byte lanes, always enabled
//
// state | meaning
// IDLE  | no access; arbitrate between pending requests
// WRITE | CE_N/WE_N low, DQ driven from the latched data for WR_CYCLES cycles
// READ  | CE_N/OE_N low for RD_CYCLES cycles; DQ sampled on the last one
// TURN  | (SRAM_TURNAROUND_EN only) bus-idle cycle after a write; o_wr_ack pulses
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  tri   [DATA_W-1:0] io_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
`ifdef SRAM_TURNAROUND_EN
    , TURN = 2'd3
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last_wr, last_wr_nxt;   // 1: last grant went to the write port
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [DATA_W-1:0] rd_data_q, rd_data_nxt;
  logic              wr_ack_q, wr_ack_nxt;
  logic              rd_ack_q, rd_ack_nxt;
  logic              wr_elig, rd_elig, grant_wr;

  // A requester still sees its own req high during its ack cycle. Masking it
  // there stops the same request from being granted twice.
  assign wr_elig  = i_wr_req & ~wr_ack_q;
  assign rd_elig  = i_rd_req & ~rd_ack_q;
  assign grant_wr = wr_elig & (~rd_elig | ~last_wr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_wr   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_wr   <= last_wr_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      rd_data_q <= rd_data_nxt;
      wr_ack_q  <= wr_ack_nxt;
      rd_ack_q  <= rd_ack_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_wr_nxt = last_wr;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rd_data_nxt = rd_data_q;
    wr_ack_nxt  = 1'b0;
    rd_ack_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_elig || rd_elig) begin
          cnt_nxt     = '0;
          last_wr_nxt = grant_wr;
          if (grant_wr) begin
            state_nxt = WRITE;
            addr_nxt  = i_wr_addr;
            wdata_nxt = i_wr_data;
          end else begin
            state_nxt = READ;
            addr_nxt  = i_rd_addr;
          end
        end
      end
      WRITE: begin
        if (cnt == WR_LAST) begin
          wr_ack_nxt = 1'b1;
          cnt_nxt    = '0;
`ifdef SRAM_TURNAROUND_EN
          state_nxt  = TURN;
`else
          state_nxt  = IDLE;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      READ: begin
        if (cnt == RD_LAST) begin
          rd_ack_nxt  = 1'b1;
          rd_data_nxt = io_sram_dq;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`ifdef SRAM_TURNAROUND_EN
      TURN: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded directly from the state register. They therefore
  // release as soon as the asynchronous reset clears the state.
  assign o_sram_we_n = (state != WRITE);
  assign o_sram_oe_n = (state != READ);
  assign o_sram_ce_n = !((state == WRITE) || (state == READ));
  assign o_sram_lb_n = 1'b0;
  assign o_sram_ub_n = 1'b0;
  assign o_sram_addr = addr_q;
  assign io_sram_dq  = (state == WRITE) ? wdata_q : {DATA_W{1'bz}};

  assign o_busy    = (state != IDLE);
  assign o_wr_ack  = wr_ack_q;
  assign o_rd_ack  = rd_ack_q;
  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int WRC = 2;
  localparam int RDC = 2;
`ifdef SRAM_TURNAROUND_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, rd_ack, busy, we_n, ce_n, oe_n, lb_n, ub_n;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  tri   [DW-1:0] dq;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
    .o_busy(busy), .o_sram_addr(sram_addr), .io_sram_dq(dq),
    .o_sram_we_n(we_n), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  // Pattern an unwritten location reads back as.
  function automatic logic [DW-1:0] fill(input logic [4:0] a);
    return {11'h0, a} ^ 16'h5A3C;
  endfunction

  // SRAM device model (pin level, 32 words, address bits above 4 ignored)
  logic [DW-1:0] dev_mem [32];
  logic [31:0]   dev_valid = '0;
  logic [DW-1:0] dev_rd = '0;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      dev_mem[sram_addr[4:0]]   <= dq;
      dev_valid[sram_addr[4:0]] <= 1'b1;
    end
  end
  always @(negedge clk)
    dev_rd <= dev_valid[sram_addr[4:0]] ? dev_mem[sram_addr[4:0]] : fill(sram_addr[4:0]);
  assign dq = (!ce_n && !oe_n) ? dev_rd : {DW{1'bz}};

  int checks = 0, failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Transaction-level reference model: the current grant and the expected ack cycles.
  int            g_cycle = -1, g_len = 0, idle_at = 0;
  int            wr_ack_at = -1, rd_ack_at = -1;
  bit            g_wr = 1'b0, last_wr = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_data = '0, exp_rd = '0, rd_pending = '0;
  logic [DW-1:0] ref_mem [32];
  logic [31:0]   ref_valid = '0;

  // Stimulus: mode 0 applies nxt_* values, mode 1 runs random requesters.
  int            mode = 0;
  logic          nxt_wr_req = 1'b0, nxt_rd_req = 1'b0;
  logic [AW-1:0] nxt_wr_addr = '0, nxt_rd_addr = '0;
  logic [DW-1:0] nxt_wr_data = '0;

  task automatic check_cycle();
    bit active, in_turn;
    logic [5:0] exp_ctl;
    if (cyc == rd_ack_at) exp_rd = rd_pending;
    active  = (g_cycle >= 0) && (cyc > g_cycle) && (cyc <= g_cycle + g_len);
    in_turn = (TURN == 1) && (g_cycle >= 0) && g_wr && (cyc == g_cycle + g_len + 1);
    exp_ctl = {!(active && g_wr), !(active && !g_wr), !active, active || in_turn,
               cyc == wr_ack_at, cyc == rd_ack_at};
    check("ctl{we,oe,ce,busy,wack,rack}", 32'({we_n, oe_n, ce_n, busy, wr_ack, rd_ack}), 32'(exp_ctl));
    check("rd_data", 32'(rd_data), 32'(exp_rd));
    check("we_oe_exclusive", 32'(!(we_n | oe_n)), 32'(0));
    check("lb_ub", 32'({lb_n, ub_n}), 32'(0));
    if (active) check("sram_addr", 32'(sram_addr), 32'(g_addr));
    if (active && g_wr) check("dq_write", 32'(dq), 32'(g_data));
  endtask

  task automatic drive_stim();
    if (mode == 0) begin
      wr_req = nxt_wr_req; wr_addr = nxt_wr_addr; wr_data = nxt_wr_data;
      rd_req = nxt_rd_req; rd_addr = nxt_rd_addr;
    end else begin
      if (wr_req) begin
        if (wr_ack) begin
          if ($urandom_range(1) == 0) wr_req = 1'b0;
          else begin wr_addr = AW'($urandom_range(31)); wr_data = DW'($urandom); end
        end
      end else if ($urandom_range(2) == 0) begin
        wr_req = 1'b1; wr_addr = AW'($urandom_range(31)); wr_data = DW'($urandom);
      end
      if (rd_req) begin
        if (rd_ack) begin
          if ($urandom_range(1) == 0) rd_req = 1'b0;
          else rd_addr = AW'($urandom_range(31));
        end
      end else if ($urandom_range(2) == 0) begin
        rd_req = 1'b1; rd_addr = AW'($urandom_range(31));
      end
    end
  endtask

  task automatic model_grant();
    bit we_ok, re_ok;
    if (cyc >= idle_at) begin
      we_ok = wr_req && (cyc != wr_ack_at);
      re_ok = rd_req && (cyc != rd_ack_at);
      if (we_ok || re_ok) begin
        g_wr    = we_ok && (!re_ok || !last_wr);
        last_wr = g_wr;
        g_cycle = cyc;
        if (g_wr) begin
          g_len = WRC; g_addr = wr_addr; g_data = wr_data;
          ref_mem[wr_addr[4:0]] = wr_data; ref_valid[wr_addr[4:0]] = 1'b1;
          wr_ack_at = cyc + WRC + 1;
          idle_at   = cyc + WRC + 1 + TURN;
        end else begin
          g_len = RDC; g_addr = rd_addr;
          rd_pending = ref_valid[rd_addr[4:0]] ? ref_mem[rd_addr[4:0]] : fill(rd_addr[4:0]);
          rd_ack_at = cyc + RDC + 1;
          idle_at   = rd_ack_at;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    check_cycle();
    drive_stim();
    model_grant();
  endtask

  // Called #1 after an edge taken with rst high; this cycle is the first IDLE cycle.
  task automatic release_reset();
    rst = 1'b0;
    g_cycle = -1; wr_ack_at = -1; rd_ack_at = -1;
    last_wr = 1'b0; exp_rd = '0; idle_at = cyc;
    check_cycle();
    drive_stim();
    model_grant();
  endtask

  task automatic drain();
    mode = 0; nxt_wr_req = 1'b0; nxt_rd_req = 1'b0;
    for (int i = 0; i < 40 && !(cyc > idle_at && cyc > wr_ack_at && cyc > rd_ack_at); i++) step();
  endtask

  initial begin
    int t0;
    // Both ports request from reset and stay high: expect W,R,W,R
    nxt_wr_req = 1'b1; nxt_wr_addr = 20'h3; nxt_wr_data = 16'h1234;
    nxt_rd_req = 1'b1; nxt_rd_addr = 20'h7;
    wr_req = 1'b1; wr_addr = 20'h3; wr_data = 16'h1234;
    rd_req = 1'b1; rd_addr = 20'h7;
    #3;
    check("reset_ctl", 32'({we_n, oe_n, ce_n, busy, wr_ack, rd_ack}), 32'(6'b111000));
    check("reset_rd_data", 32'(rd_data), 32'(0));
    check("reset_addr", 32'(sram_addr), 32'(0));
    @(posedge clk); #1;
    cyc = 0;
    release_reset();
    repeat (13) step();

    drain();
    nxt_wr_req = 1'b1; nxt_wr_addr = 20'h00010; nxt_wr_data = 16'hA5A5;
    step();
    t0 = cyc;
    for (int i = 0; i < 10 && !wr_ack; i++) step();
    check("wr_ack_latency", 32'(cyc - t0), 32'(WRC + 1));
    nxt_wr_req = 1'b0;
    step();
    nxt_rd_req = 1'b1; nxt_rd_addr = 20'h00010;
    step();
    t0 = cyc;
    for (int i = 0; i < 10 && !rd_ack; i++) step();
    check("rd_ack_latency", 32'(cyc - t0), 32'(RDC + 1));
    check("rd_data_a5a5", 32'(rd_data), 32'(16'hA5A5));
    nxt_rd_req = 1'b0;

    drain();
    mode = 1;
    repeat (600) step();
    drain();

    // Reset in the first WRITE cycle, then a fresh write afterwards
    nxt_wr_req = 1'b1; nxt_wr_addr = 20'h5; nxt_wr_data = 16'hBEEF;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    check("async_rst_ctl", 32'({we_n, oe_n, ce_n, busy, wr_ack, rd_ack}), 32'(6'b111000));
    check("async_rst_rd_data", 32'(rd_data), 32'(0));
    @(posedge clk); #1;
    cyc++;
    release_reset();
    t0 = cyc;
    for (int i = 0; i < 10 && !wr_ack; i++) step();
    check("wr_after_rst_latency", 32'(cyc - t0), 32'(WRC + 1));
    nxt_wr_req = 1'b0;
    drain();

    nxt_rd_req = 1'b1; nxt_rd_addr = 20'h5;
    step();
    for (int i = 0; i < 10 && !rd_ack; i++) step();
    check("rd_after_rst_data", 32'(rd_data), 32'(16'hBEEF));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
